// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and constants for the digit-serial BCD add/sub.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_ADJ   = 4'd6;
  localparam logic [3:0] BCD_RADIX = 4'd10;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
// ============================================================================
// Module  : bcd_digit_addsub
// Brief   : Combinational single BCD digit adder/subtractor with carry/borrow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       op,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] w_sum;
  logic [5:0] w_diff;

  assign w_sum   = {1'b0, x} + {1'b0, y} + {4'd0, cin};
  assign w_diff  = {2'b00, x} - {2'b00, y} - {5'd0, cin};
  assign invalid = (x > BCD_MAX) || (y > BCD_MAX);

  // Both corrections only need the low nibble: +6 and +10 wrap modulo 16.
  always_comb begin
    digit = 4'd0;
    cout  = 1'b0;
    if (op == OP_ADD) begin
      if (w_sum > {1'b0, BCD_MAX}) begin
        digit = w_sum[3:0] + BCD_ADJ;
        cout  = 1'b1;
      end else begin
        digit = w_sum[3:0];
      end
    end else begin
      if (w_diff[5]) begin
        digit = w_diff[3:0] + BCD_RADIX;
        cout  = 1'b1;
      end else begin
        digit = w_diff[3:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
// ============================================================================
// Module  : bcd_serial_addsub
// Brief   : Digit-serial BCD adder/subtractor, LSD first, valid/ready I/O.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_x,
  input  logic [4*DIGITS-1:0] in_y,
  input  logic                in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_sum,
  output logic                out_ovf,
  output logic                out_neg,
  output logic                out_err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_op;
  logic             r_cy;
  logic             r_err;
  logic [W-1:0]     r_res;
  logic [W-1:0]     r_sum;
  logic             r_ovf;
  logic             r_neg;
  logic             r_err_o;

  logic [3:0]       w_digit;
  logic             w_cout;
  logic             w_invalid;
  logic [W-1:0]     w_res;
  logic             w_err;
  logic [W-1:0]     w_fin_sum;
  logic             w_fin_ovf;
  logic             w_fin_neg;

  bcd_digit_addsub u_digit (
    .x       (r_x[3:0]),
    .y       (r_y[3:0]),
    .op      (r_op),
    .cin     (r_cy),
    .digit   (w_digit),
    .cout    (w_cout),
    .invalid (w_invalid)
  );

  // Result digits enter at the top so digit 0 lands in [3:0] after DIGITS shifts.
  assign w_res = {w_digit, r_res[W-1:4]};
  assign w_err = r_err | w_invalid;

  always_comb begin
    w_fin_sum = w_res;
    w_fin_ovf = 1'b0;
    w_fin_neg = 1'b0;
    if (w_err) begin
      w_fin_sum = '0;
    end else if (r_op == OP_ADD && w_cout) begin
      w_fin_ovf = 1'b1;
      if (SAT_EN) w_fin_sum = {DIGITS{BCD_MAX}};
    end else if (r_op == OP_SUB && w_cout) begin
      w_fin_neg = 1'b1;
      if (SAT_EN) w_fin_sum = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_op    <= OP_ADD;
      r_cy    <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_err_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= in_x;
            r_y     <= in_y;
            r_op    <= in_op;
            r_cy    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_x   <= {4'd0, r_x[W-1:4]};
          r_y   <= {4'd0, r_y[W-1:4]};
          r_res <= w_res;
          r_cy  <= w_cout;
          r_err <= w_err;
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_fin_sum;
            r_ovf   <= w_fin_ovf;
            r_neg   <= w_fin_neg;
            r_err_o <= w_err;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_ovf   = r_ovf;
  assign out_neg   = r_neg;
  assign out_err   = r_err_o;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
// ============================================================================
// Module  : tb_bcd_serial_addsub
// Brief   : Randomised self-checking bench, saturating and wrapping instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_op;
  logic         out_ready;

  logic         in_ready_s1, out_valid_s1, out_ovf_s1, out_neg_s1, out_err_s1;
  logic [W-1:0] out_sum_s1;
  logic         in_ready_s0, out_valid_s0, out_ovf_s0, out_neg_s0, out_err_s0;
  logic [W-1:0] out_sum_s0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(DIGITS), .SAT_EN(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s1),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid_s1), .out_ready(out_ready),
    .out_sum(out_sum_s1), .out_ovf(out_ovf_s1), .out_neg(out_neg_s1), .out_err(out_err_s1)
  );

  bcd_serial_addsub #(.DIGITS(DIGITS), .SAT_EN(1'b0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s0),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid_s0), .out_ready(out_ready),
    .out_sum(out_sum_s0), .out_ovf(out_ovf_s0), .out_neg(out_neg_s0), .out_err(out_err_s0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal-value reference: returns {err, neg, ovf, sum}.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic op, input bit sat);
    int xv = 0, yv = 0, r, lim = 1;
    bit bad = 0, ovf = 0, neg = 0;
    logic [W-1:0] s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) bad = 1;
      xv = xv * 10 + int'(x[4*i +: 4]);
      yv = yv * 10 + int'(y[4*i +: 4]);
      lim = lim * 10;
    end
    if (bad) return {1'b1, 1'b0, 1'b0, {W{1'b0}}};
    r = op ? xv - yv : xv + yv;
    if (!op && r >= lim) begin ovf = 1; r = sat ? lim - 1 : r - lim; end
    if (op && r < 0)     begin neg = 1; r = sat ? 0 : r + lim; end
    for (int i = 0; i < DIGITS; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, neg, ovf, s};
  endfunction

  task automatic check_result(input string tag, input logic [W+2:0] e1, input logic [W+2:0] e0);
    check_eq({tag, "_sum_sat"},  32'(out_sum_s1), 32'(e1[W-1:0]));
    check_eq({tag, "_ovf_sat"},  32'(out_ovf_s1), 32'(e1[W]));
    check_eq({tag, "_neg_sat"},  32'(out_neg_s1), 32'(e1[W+1]));
    check_eq({tag, "_err_sat"},  32'(out_err_s1), 32'(e1[W+2]));
    check_eq({tag, "_sum_wrap"}, 32'(out_sum_s0), 32'(e0[W-1:0]));
    check_eq({tag, "_ovf_wrap"}, 32'(out_ovf_s0), 32'(e0[W]));
    check_eq({tag, "_neg_wrap"}, 32'(out_neg_s0), 32'(e0[W+1]));
    check_eq({tag, "_err_wrap"}, 32'(out_err_s0), 32'(e0[W+2]));
  endtask

  // One full transaction; result is held for 'hold' cycles of backpressure
  // while fresh operands are offered (and must be ignored).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                        input int hold, input string tag);
    logic [W+2:0] e1, e0;
    logic [W-1:0] held1, held0;
    e1 = model(x, y, op, 1'b1);
    e0 = model(x, y, op, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_in_ready"}, 32'(in_ready_s1 & in_ready_s0), 32'd1);
    in_valid = 1'b1; in_x = x; in_y = y; in_op = op;
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_op = ~op;
    check_eq({tag, "_busy"}, 32'(in_ready_s1 | in_ready_s0), 32'd0);
    repeat (DIGITS - 1) @(posedge clk);
    #1;
    check_eq({tag, "_early"}, 32'(out_valid_s1 | out_valid_s0), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 32'(out_valid_s1 & out_valid_s0), 32'd1);
    check_result(tag, e1, e0);
    held1 = out_sum_s1;
    held0 = out_sum_s0;
    for (int k = 0; k < hold; k++) begin
      in_x = $urandom; in_y = $urandom; in_op = $urandom;
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 32'(out_valid_s1 & out_valid_s0), 32'd1);
      check_eq({tag, "_hold_rdy"},   32'(in_ready_s1 | in_ready_s0), 32'd0);
      check_eq({tag, "_hold_sum"},   32'({out_sum_s1, out_sum_s0}), 32'({held1, held0}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_drain"}, 32'(out_valid_s1 | out_valid_s0), 32'd0);
    check_eq({tag, "_idle"},  32'(in_ready_s1 & in_ready_s0), 32'd1);
    check_result({tag, "_kept"}, e1, e0);
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++)
      v[4*i +: 4] = (allow_bad && $urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                                               : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_op = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready",  32'(in_ready_s1 & in_ready_s0), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid_s1 | out_valid_s0), 32'd0);
    check_eq("rst_out_sum",   32'({out_sum_s1, out_sum_s0}), 32'd0);
    check_eq("rst_flags",     32'({out_ovf_s1, out_neg_s1, out_err_s1,
                                   out_ovf_s0, out_neg_s0, out_err_s0}), 32'd0);

    run_op(16'h1234, 16'h5678, 1'b0, 0, "add_basic");
    check_eq("add_basic_literal", 32'(out_sum_s1), 32'h6912);
    run_op(16'h9999, 16'h0001, 1'b0, 0, "add_ovf");
    run_op(16'h0500, 16'h0123, 1'b1, 0, "sub_pos");
    run_op(16'h0123, 16'h0500, 1'b1, 0, "sub_neg");
    check_eq("sub_neg_wrap_literal", 32'(out_sum_s0), 32'h9623);
    run_op(16'h12A4, 16'h0001, 1'b0, 0, "err_add");
    run_op(16'h0001, 16'h00F0, 1'b1, 0, "err_sub");
    run_op(16'h0000, 16'h0000, 1'b1, 0, "zero_sub");
    run_op(16'h4321, 16'h8765, 1'b0, 10, "backpressure");

    // Stray out_ready while idle must not create a result.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("idle_out_ready", 32'(out_valid_s1 | out_valid_s0), 32'd0);

    for (int n = 0; n < 40; n++)
      run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), int'($urandom_range(0, 3)), "rand");

    // Asynchronous reset in the middle of a calculation (idx==2).
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = 16'h9876; in_y = 16'h1111; in_op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid_s1 | out_valid_s0), 32'd0);
    check_eq("arst_in_ready",  32'(in_ready_s1 & in_ready_s0), 32'd1);
    check_eq("arst_out_sum",   32'({out_sum_s1, out_sum_s0}), 32'd0);
    #10 rst_n = 1'b1;
    repeat (DIGITS + 2) @(posedge clk);
    #1;
    check_eq("arst_discarded", 32'(out_valid_s1 | out_valid_s0), 32'd0);
    run_op(16'h0042, 16'h0058, 1'b0, 0, "post_rst");
    check_eq("post_rst_literal", 32'(out_sum_s1), 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, digit-serial BCD adder/subtractor, DIGITS decimal digits wide.
- Processes one BCD digit per clock, least-significant digit first, and uses a valid/ready handshake on both input and output.
- Adds a subtract mode, selectable saturation, and detection of invalid (non-BCD) digits.
- Sits in the arithmetic datapath as the general replacement for fixed-width combinational BCD adders; saturating add to all-9s remains available.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=2); the data width W = 4*DIGITS.
- SAT_EN, 1, 1 = clamp on overflow/underflow; 0 = wrap (modulo 10^DIGITS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- in_x  in  W  operand X, packed BCD, digit 0 in [3:0].
- in_y  in  W  operand Y, packed BCD.
- in_op  in  1  0 = X+Y, 1 = X-Y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  packed BCD result.
- out_ovf  out  1  add produced a carry out of the top digit.
- out_neg  out  1  subtract result was negative (borrow out of the top digit).
- out_err  out  1  an operand contained a nibble > 9.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, digit counter=0, carry/borrow=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_neg=0, out_err=0. An operation in flight is discarded with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_x, in_y and in_op, clear carry/borrow and err, set idx=0, go to CALC.
  - CALC: in_ready=0. Each cycle computes digit idx, writes it into the result register, updates carry/borrow, and ORs the invalid-digit check into err. When idx==DIGITS-1, go to DONE; otherwise idx+1.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE.
- Latency: out_valid rises exactly DIGITS cycles after the accepting edge.
- Throughput: one operation per DIGITS+2 cycles, with one IDLE bubble after each result.
- Add digit: s = x+y+c (5 bits). If s>9: digit=(s+6)[3:0], c=1; else digit=s[3:0], c=0.
- Subtract digit: d = x-y-b. If d<0: digit=d+10, b=1; else digit=d, b=0.
- Finalisation at the CALC-to-DONE edge, highest priority first:
  1. err=1: out_sum=0, out_ovf=0, out_neg=0, out_err=1.
  2. Add with c=1: out_ovf=1; out_sum = all 9s if SAT_EN, else the wrapped digits.
  3. Subtract with b=1: out_neg=1; out_sum = 0 if SAT_EN, else the ten's-complement wrapped digits.
  4. Otherwise: out_sum = computed digits, all flags 0.
- Output registers hold stable while out_valid=1 and out_ready=0; unbounded backpressure is allowed.
- in_valid while in_ready=0 is ignored. Operands are captured only on the handshake, so input changes after capture have no effect.
- out_ready while out_valid=0 is ignored.
- Flags and out_sum are meaningful only while out_valid=1. They retain their last values in IDLE and CALC.
- Digit counter width is max(1, clog2(DIGITS)) and never wraps past DIGITS-1.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - OP_ADD=0 and OP_SUB=1;
  - BCD_MAX=4'd9, BCD_ADJ=4'd6 and BCD_RADIX=4'd10.
- One natural sub-module, bcd_digit_addsub: a combinational single-digit cell.
  - Inputs: x, y, op, cin.
  - Outputs: digit, cout, invalid.
- The top level contains only the FSM, the counter, the operand/result shift registers and the finalisation logic.

Test Plan:
- DIGITS=4, SAT_EN=1, 1234+5678 -> out_sum=6912, all flags 0, out_valid exactly 4 cycles after the accepting edge.
- 9999+0001 -> SAT_EN=1: out_sum=9999, ovf=1. SAT_EN=0: out_sum=0000, ovf=1.
- 0500-0123 -> 0377, neg=0. 0123-0500 -> SAT_EN=1: 0000, neg=1. SAT_EN=0: 9623, neg=1.
- Invalid digits: 12A4+0001 -> out_sum=0000, err=1, ovf=0. Also 0001-00F0 -> err=1.
- Backpressure: hold out_ready=0 for 10 cycles while pulsing in_valid with new operands.
  - Outputs stay constant, in_ready stays 0, and the new operands are not captured.
  - After release, exactly one result has been delivered and in_ready=1 the next cycle.
- Reset: drive rst_n low during CALC at idx=2.
  - Asynchronously: out_valid=0, in_ready=1.
  - After release, 0042+0058 -> 0100 with correct latency.
